// File: rtl/rd_ptr_empty_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rd_ptr_empty_ctrl                                          |
// | Description : Read-side controller of a dual-clock FIFO, entirely in the |
// |               rd_clk domain. It synchronises the write-domain Gray       |
// |               pointer, owns the binary/Gray read pointer and the RAM     |
// |               read address, and produces a registered empty flag, a      |
// |               sticky underflow flag and optional occupancy outputs.      |
// |                                                                          |
// | Parameters  : ADDR_W    - RAM address width, depth = 2**ADDR_W           |
// |               AE_THRESH - almost_empty asserts when level <= AE_THRESH   |
// |                                                                          |
// | Ports       : rd_clk       in   read clock, rising edge                  |
// |               rd_rst       in   synchronous active-high reset            |
// |               rd_en        in   consumer read request                    |
// |               wr_ptr_gray  in   write pointer (Gray, unsynchronised)     |
// |               rd_ack       out  read accepted this cycle (combinational) |
// |               rd_addr      out  registered RAM read address              |
// |               rd_ptr       out  registered Gray read pointer             |
// |               empty        out  registered empty flag                    |
// |               almost_empty out  registered, level <= AE_THRESH           |
// |               rd_level     out  registered occupancy 0..2**ADDR_W        |
// |               underflow    out  sticky, read request while empty         |
// |                                                                          |
// | Build macro : RD_PTR_LEVEL_EN - when defined, the Gray-to-binary decoder,|
// |               level subtractor and threshold compare are built. When     |
// |               undefined, rd_level is 0 and almost_empty follows empty.   |
// |                                                                          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module rd_ptr_empty_ctrl #(
    parameter int ADDR_W    = 3,
    parameter int AE_THRESH = 1
) (
    input  logic              rd_clk,
    input  logic              rd_rst,
    input  logic              rd_en,
    input  logic [ADDR_W:0]   wr_ptr_gray,
    output logic              rd_ack,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W:0]   rd_ptr,
    output logic              empty,
    output logic              almost_empty,
    output logic [ADDR_W:0]   rd_level,
    output logic              underflow
);

    // Two-flop synchroniser for the write pointer; only r_rq2 is consumed.
    logic [ADDR_W:0] r_rq1;
    logic [ADDR_W:0] r_rq2;

    // Binary read counter, one bit wider than the address to tell full/empty.
    logic [ADDR_W:0] r_rd_bin;

    logic            w_rd_fire;
    logic [ADDR_W:0] w_rd_bin_nxt;
    logic [ADDR_W:0] w_rd_gray_nxt;

    assign w_rd_fire     = rd_en & ~empty;
    assign rd_ack        = w_rd_fire;
    assign w_rd_bin_nxt  = r_rd_bin + {{ADDR_W{1'b0}}, w_rd_fire};
    assign w_rd_gray_nxt = w_rd_bin_nxt ^ (w_rd_bin_nxt >> 1);

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            r_rq1 <= '0;
            r_rq2 <= '0;
        end else begin
            r_rq1 <= wr_ptr_gray;
            r_rq2 <= r_rq1;
        end
    end

    // Outputs are computed from the post-read pointer so that empty already
    // accounts for the word consumed at this edge (no extra bubble).
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            r_rd_bin  <= '0;
            rd_ptr    <= '0;
            rd_addr   <= '0;
            empty     <= 1'b1;
            underflow <= 1'b0;
        end else begin
            r_rd_bin  <= w_rd_bin_nxt;
            rd_ptr    <= w_rd_gray_nxt;
            rd_addr   <= w_rd_bin_nxt[ADDR_W-1:0];
            empty     <= (w_rd_gray_nxt == r_rq2);
            underflow <= underflow | (rd_en & empty);
        end
    end

`ifdef RD_PTR_LEVEL_EN
    localparam logic [ADDR_W:0] c_AE_THRESH = (ADDR_W + 1)'(AE_THRESH);

    logic [ADDR_W:0] w_wbin;
    logic [ADDR_W:0] w_lvl_nxt;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    for (genvar gi = 0; gi <= ADDR_W; gi++) begin : g_gray2bin
        assign w_wbin[gi] = ^r_rq2[ADDR_W:gi];
    end

    // Modulo subtraction stays correct across pointer wrap.
    assign w_lvl_nxt = w_wbin - w_rd_bin_nxt;

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            rd_level     <= '0;
            almost_empty <= 1'b1;
        end else begin
            rd_level     <= w_lvl_nxt;
            almost_empty <= (w_lvl_nxt <= c_AE_THRESH);
        end
    end
`else
    assign rd_level     = '0;
    assign almost_empty = empty;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rd_ptr_empty_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_rd_ptr_empty_ctrl                                       |
// | Description : Self-checking bench for rd_ptr_empty_ctrl. A reference    |
// |               model tracks the FIFO as integer counts (words written,    |
// |               words read) plus a two-entry delay line for the write      |
// |               count seen across the clock crossing.                      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_rd_ptr_empty_ctrl;

    localparam int ADDR_W    = 3;
    localparam int AE_THRESH = 2;
    localparam int DEPTH     = 1 << ADDR_W;
    localparam int PMOD      = 2 * DEPTH;

    logic              rd_clk;
    logic              rd_rst;
    logic              rd_en;
    logic [ADDR_W:0]   wr_ptr_gray;
    logic              rd_ack;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W:0]   rd_ptr;
    logic              empty;
    logic              almost_empty;
    logic [ADDR_W:0]   rd_level;
    logic              underflow;

    rd_ptr_empty_ctrl #(
        .ADDR_W    (ADDR_W),
        .AE_THRESH (AE_THRESH)
    ) u_dut (
        .rd_clk       (rd_clk),
        .rd_rst       (rd_rst),
        .rd_en        (rd_en),
        .wr_ptr_gray  (wr_ptr_gray),
        .rd_ack       (rd_ack),
        .rd_addr      (rd_addr),
        .rd_ptr       (rd_ptr),
        .empty        (empty),
        .almost_empty (almost_empty),
        .rd_level     (rd_level),
        .underflow    (underflow)
    );

    initial rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: counts modulo 2*DEPTH.
    int wr_cnt;        // words the writer has produced
    int m_rd;          // words consumed
    int m_lvl;         // occupancy as seen by the read side
    bit m_empty;
    bit m_uf;
    int sync_q[$];     // write counts in flight through the crossing

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned to_gray(input int unsigned b);
        return b ^ (b >> 1);
    endfunction

    task automatic model_edge(input bit rst, input bit en, input int wr);
        int seen;
        if (rst) begin
            sync_q  = '{0, 0};
            m_rd    = 0;
            m_lvl   = 0;
            m_empty = 1'b1;
            m_uf    = 1'b0;
        end else begin
            seen = sync_q.pop_front();
            sync_q.push_back(wr);
            if (en && m_empty) m_uf = 1'b1;
            if (en && !m_empty) m_rd = (m_rd + 1) % PMOD;
            m_lvl   = (seen - m_rd + PMOD) % PMOD;
            m_empty = (m_lvl == 0);
        end
    endtask

    task automatic check_state();
        check("rd_addr",   rd_addr,   m_rd % DEPTH);
        check("rd_ptr",    rd_ptr,    to_gray(m_rd));
        check("empty",     empty,     m_empty);
        check("underflow", underflow, m_uf);
`ifdef RD_PTR_LEVEL_EN
        check("rd_level",     rd_level,     m_lvl);
        check("almost_empty", almost_empty, (m_empty ? 1 : (m_lvl <= AE_THRESH)));
`else
        check("rd_level",     rd_level,     0);
        check("almost_empty", almost_empty, m_empty);
`endif
    endtask

    // One cycle: drive at negedge, check rd_ack, clock, update model, check state.
    task automatic step(input bit rst, input bit en, input int wr);
        rd_rst      = rst;
        rd_en       = en;
        wr_ptr_gray = (ADDR_W + 1)'(to_gray(wr));
        #1;
        check("rd_ack", rd_ack, en && !m_empty);
        @(posedge rd_clk);
        model_edge(rst, en, wr);
        @(negedge rd_clk);
        check_state();
    endtask

    initial begin
        rd_rst      = 1'b1;
        rd_en       = 1'b0;
        wr_ptr_gray = 4'b0110;
        wr_cnt      = 0;
        sync_q      = '{0, 0};
        m_rd        = 0;
        m_lvl       = 0;
        m_empty     = 1'b1;
        m_uf        = 1'b0;
        @(negedge rd_clk);

        // Reset held for two edges with a non-zero write pointer present.
        step(1'b1, 1'b0, 4);
        step(1'b1, 1'b0, 4);
        wr_cnt = 0;

        // Single word: empty falls on the third edge, then one read drains it.
        wr_cnt = 1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, wr_cnt);
        check("single_level_known", m_lvl, 1);
        step(1'b0, 1'b1, wr_cnt);
        check("single_rd_ptr", rd_ptr, 4'b0001);
        step(1'b0, 1'b0, wr_cnt);

        // Advance reader to 4, then writer to 8 and drain through the wrap.
        wr_cnt = 4;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, wr_cnt);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, wr_cnt);
        wr_cnt = 8;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, wr_cnt);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, wr_cnt);
        check("wrap_addr", rd_addr, 0);
        check("wrap_ptr",  rd_ptr,  4'b1100);

        // Underflow: reads while empty set the sticky flag; pointers hold.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, wr_cnt);
        check("uf_set", underflow, 1);
        step(1'b0, 1'b0, wr_cnt);

        // Level 3 then reads through the almost-empty threshold.
        wr_cnt = 11;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, wr_cnt);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, wr_cnt);

        // Glitch on rd_rst between edges must be ignored.
        wr_cnt = 14;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, wr_cnt);
        rd_rst = 1'b1;
        #2;
        rd_rst = 1'b0;
        step(1'b0, 1'b0, wr_cnt);

        // Mid-operation reset with reads active; writer resets alongside.
        step(1'b1, 1'b1, wr_cnt);
        wr_cnt = 0;
        step(1'b0, 1'b0, wr_cnt);

        // Randomised traffic with rare resets; writer never overfills.
        for (int i = 0; i < 3000; i++) begin
            bit do_rst;
            bit en;
            do_rst = ($urandom_range(0, 299) == 0);
            en     = ($urandom_range(0, 99) < 45);
            if (!do_rst && ($urandom_range(0, 99) < 50) &&
                (((wr_cnt - m_rd + PMOD) % PMOD) < DEPTH))
                wr_cnt = (wr_cnt + 1) % PMOD;
            step(do_rst, en, wr_cnt);
            if (do_rst) wr_cnt = 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rd_ptr_empty_ctrl.md
# rd_ptr_empty_ctrl

Parametrised read-side controller for the dual-clock FIFO, running entirely in the read clock domain. It synchronises the write-domain Gray pointer, owns the binary/Gray read pointer and RAM read address, and generates registered `empty`. It also provides occupancy (`rd_level`), `almost_empty` and a sticky underflow flag. It sits between the FIFO storage RAM read port and the consumer, with `rd_ptr` returned to the write-side controller.

## Interface
- `ADDR_W`, default 3: RAM address width; FIFO depth = 2^ADDR_W; pointers are ADDR_W+1 bits.
- `AE_THRESH`, default 1: `almost_empty` asserts when occupancy <= AE_THRESH; legal range 0..2^ADDR_W.

- `rd_clk`  in  1  read-domain clock; all state updates on rising edge.
- `rd_rst`  in  1  reset, synchronous to `rd_clk`, active-high.
- `rd_en`  in  1  consumer read request.
- `wr_ptr_gray`  in  ADDR_W+1  write pointer, Gray coded, from the write clock domain (unsynchronised).
- `rd_ack`  out  1  combinational `rd_en & ~empty`; read accepted this cycle.
- `rd_addr`  out  ADDR_W  registered RAM read address.
- `rd_ptr`  out  ADDR_W+1  registered Gray read pointer, sent to the write domain.
- `empty`  out  1  registered empty flag.
- `almost_empty`  out  1  registered; occupancy <= AE_THRESH.
- `rd_level`  out  ADDR_W+1  registered occupancy, 0..2^ADDR_W.
- `underflow`  out  1  sticky; set by a read request while empty.

## Operation
- Synchroniser: `rq1 <= wr_ptr_gray; rq2 <= rq1`. No logic between the two stages. Only `rq2` is used downstream.
- Binary read counter `rd_bin` (ADDR_W+1 bits):
  - `rd_fire = rd_en & ~empty`
  - `rd_bin_nxt = rd_bin + rd_fire`, wrapping modulo 2^(ADDR_W+1).
- Registered outputs:
  - `rd_ptr <= rd_bin_nxt ^ (rd_bin_nxt >> 1)`
  - `rd_addr <= rd_bin_nxt[ADDR_W-1:0]`
  - `empty <= (gray(rd_bin_nxt) == rq2)`
- `rd_addr` and `rd_ptr` always point at the next word to be read. Data at `rd_addr` is valid whenever `empty`=0.
- Occupancy:
  - `wbin = gray2bin(rq2)`
  - `lvl_nxt = wbin - rd_bin_nxt`, mod 2^(ADDR_W+1)
  - `rd_level <= lvl_nxt`
  - `almost_empty <= (lvl_nxt <= AE_THRESH)`
- Underflow: `rd_en & empty` sets `underflow` at the next edge. The read is ignored and pointers hold. Only `rd_rst` clears it.
- Reset values, applied at the first `rd_clk` edge with `rd_rst`=1: `rq1`=`rq2`=0, `rd_bin`=0, `rd_ptr`=0, `rd_addr`=0, `empty`=1, `almost_empty`=1, `rd_level`=0, `underflow`=0. `rd_ack` is 0 while `empty`=1.
- Reset mid-operation discards all state, including synchronised pointer history. The FIFO-level reset sequence resets the write side together with the read side.

## Timing
- Write-pointer change to `empty`/`rd_level` update: 3 `rd_clk` edges (2 synchroniser stages plus 1 output register).
- Read accepted at edge N (`rd_en`=1, `empty`=0 before the edge):
  - `rd_ptr`, `rd_addr` and `rd_level` update at edge N.
  - `empty` reflects the last word consumed at edge N, so there is no extra bubble.
- Back-to-back reads sustain 1 word/cycle until empty.
- Pointer wrap: after 2^ADDR_W reads `rd_addr` returns to 0. Gray `rd_ptr` wraps after 2^(ADDR_W+1) reads. Exactly one bit changes per increment, including at wrap.
- Simultaneous write-side update and read: `lvl_nxt` uses the current `rq2` and `rd_bin_nxt`, so the result is consistent.
- `empty` is pessimistic: it may lag a write by 3 edges and never deasserts early.
- `rd_rst` is sampled only at clock edges. A pulse between edges has no effect.

## Configuration
- `RD_PTR_LEVEL_EN` defined:
  - `rd_level` and `almost_empty` logic (gray2bin decoder, subtractor, comparator) is compiled in.
- `RD_PTR_LEVEL_EN` undefined:
  - No decoder or subtractor is built.
  - `rd_level` is tied to 0 and `almost_empty` is tied to `empty`.
  - All other behaviour and timing are identical.

## Test plan
- Reset: hold `rd_rst`=1 for 2 edges with `wr_ptr_gray`=4'b0110 -> `empty`=1, `almost_empty`=1, `rd_ptr`=0, `rd_addr`=0, `rd_level`=0, `underflow`=0.
- Single word: `ADDR_W`=3, `wr_ptr_gray`=0001 -> `empty` falls on the 3rd edge with `rd_level`=1. One `rd_en` cycle -> `rd_ack`=1, then `rd_ptr`=0001, `rd_addr`=1, `empty`=1, `rd_level`=0.
- Full drain with wrap: start with `rd_bin`=4, `wr_ptr_gray`=1100 (bin 8) -> `rd_level`=4. Hold `rd_en` -> `rd_addr` goes 5,6,7,0. `rd_ptr` Gray goes 0111,0101,0100,1100. `empty`=1 after the 4th read.
- Underflow: `rd_en`=1 while `empty`=1 -> `rd_ack`=0, `underflow`=1 next edge, `rd_ptr` unchanged. `underflow` stays 1 until `rd_rst`.
- Almost-empty: `AE_THRESH`=2, level 3 -> `almost_empty`=0. One read -> `rd_level`=2, `almost_empty`=1. With `RD_PTR_LEVEL_EN` undefined -> `almost_empty`==`empty` and `rd_level`==0 throughout.
- Mid-operation reset: level 5, `rd_en` active, `rd_rst`=1 at one edge -> all reset values next cycle. A `rd_rst` glitch between edges -> no change.
